debug_reply_framer: RTL

Buffered, parametrised successor to the single-shot debug reply path. It queues reply requests from the debug coprocessor (command plus payload) in a FIFO. Each entry is serialised onto the debug UART TX as a framed byte stream: sync byte, command byte, payload bytes MSB-first, and an optional checksum. It sits between the coprocessor's reply outputs and the debug UART TX handshake, so the coprocessor never stalls on a reply unless the FIFO is full.

---
 rtl/debug_reply_pkg.sv | 27 ++
 rtl/debug_reply_fifo.sv | 53 +++++
 rtl/debug_reply_framer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/debug_reply_pkg.sv
// Shared types and helpers for the debug reply framer: FSM states, default sync
// byte and the frame checksum.
package debug_reply_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h5A;
    localparam int MAX_PAYLOAD_BYTES = 8;

    // Unused high payload bytes must be zero; they then add nothing to the sum.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0]                     cmd_byte,
        input logic [MAX_PAYLOAD_BYTES*8-1:0] payload
    );
        logic [7:0] sum;
        sum = cmd_byte;
        for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            sum = sum + payload[i*8 +: 8];
        end
        return 8'h00 - sum;
    endfunction

endpackage

// File: rtl/debug_reply_fifo.sv
// Synchronous register-based FIFO; the head entry is always visible on rd_data
// so the consumer can capture it in the same cycle it pops.
module debug_reply_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/debug_reply_framer.sv
// Queues debug coprocessor replies and serialises each one onto the UART TX
// handshake as: sync, command, payload MSB-first, optional checksum.
module debug_reply_framer
    import debug_reply_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         CMD_WIDTH     = 8,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         CHECKSUM_EN   = 1,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
    input  logic                           clk,
    input  logic                           sync_reset,
    input  logic                           reply_enable_in,
    input  logic [CMD_WIDTH-1:0]           reply_debug_cmd,
    input  logic [PAYLOAD_BYTES*8-1:0]     reply_payload,
    output logic                           reply_ready,
    input  logic                           uart_tx_done,
    output logic                           ctl_start_uart_tx,
    output logic [7:0]                     uart_data_out,
    output logic                           reply_done,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overflow
);

    localparam int ENTRY_W     = CMD_WIDTH + PAYLOAD_BYTES*8;
    localparam int FRAME_BYTES = 2 + PAYLOAD_BYTES + CHECKSUM_EN;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t                        state;
    logic [IDX_W-1:0]              byte_idx;
    logic [IDX_W-1:0]              next_idx;
    logic [7:0]                    frame      [FRAME_BYTES];
    logic [7:0]                    next_frame [FRAME_BYTES];

    logic                          full;
    logic                          empty;
    logic                          push;
    logic                          pop;
    logic [ENTRY_W-1:0]            head;
    logic [CMD_WIDTH-1:0]          head_cmd;
    logic [PAYLOAD_BYTES*8-1:0]    head_payload;
    logic [7:0]                    cmd_byte;
    logic [MAX_PAYLOAD_BYTES*8-1:0] payload_ext;

    assign push         = reply_enable_in && !full;
    assign pop          = (state == IDLE) && !empty;
    assign head_cmd     = head[ENTRY_W-1 -: CMD_WIDTH];
    assign head_payload = head[PAYLOAD_BYTES*8-1:0];
    assign next_idx     = byte_idx + IDX_W'(1);
    assign reply_ready  = !full;
    assign busy         = (state != IDLE) || (fifo_level != '0);

    debug_reply_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (push),
        .wr_data    ({reply_debug_cmd, reply_payload}),
        .pop        (pop),
        .rd_data    (head),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level)
    );

    // Whole frame, checksum included, is built from the FIFO head during the pop cycle.
    always_comb begin
        for (int i = 0; i < FRAME_BYTES; i++) next_frame[i] = 8'h00;
        cmd_byte = '0;
        cmd_byte[CMD_WIDTH-1:0] = head_cmd;
        payload_ext = '0;
        payload_ext[PAYLOAD_BYTES*8-1:0] = head_payload;
        next_frame[0] = SYNC_BYTE;
        next_frame[1] = cmd_byte;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            next_frame[IDX_W'(2 + i)] = head_payload[(PAYLOAD_BYTES-1-i)*8 +: 8];
        end
        if (CHECKSUM_EN != 0) next_frame[FRAME_BYTES-1] = frame_checksum(cmd_byte, payload_ext);
    end

    always_ff @(posedge clk) begin
        if (pop) frame <= next_frame;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state             <= IDLE;
            byte_idx          <= '0;
            ctl_start_uart_tx <= 1'b0;
            uart_data_out     <= 8'h00;
            reply_done        <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            ctl_start_uart_tx <= 1'b0;
            reply_done        <= 1'b0;
            // A full FIFO drops the push even when a pop frees a slot this cycle.
            if (reply_enable_in && full) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        byte_idx          <= '0;
                        uart_data_out     <= next_frame[0];
                        ctl_start_uart_tx <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (uart_tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            reply_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            byte_idx          <= next_idx;
                            uart_data_out     <= frame[next_idx];
                            ctl_start_uart_tx <= 1'b1;
                            state             <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
